pixel_writer: RTL and testbench
===============================

# pixel_writer

Consumer end of the rasterizer pixel stream: accepts (x, y, valid) from the line/shape drawer, clips off-screen pixels, converts coordinates to framebuffer byte addresses and issues single-beat Avalon-MM writes to the SDRAM framebuffer. It back-pressures the drawer through `stall` so that no accepted pixel is ever lost, and reports when a primitive has fully reached memory.

## Interface

Parameters:
- H_RES, 640: visible width in pixels; x >= H_RES is clipped.
- V_RES, 480: visible height in pixels; y >= V_RES is clipped.
- BASE_ADDR, 32'h0000_0000: framebuffer byte base address.
- FIFO_DEPTH, 8: write FIFO entries; power of two, minimum 8.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low (`clock`, `reset_n`).
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- x  in  12  pixel column from the drawer, unsigned.
- y  in  12  pixel row from the drawer, unsigned.
- valid  in  1  x/y hold a new pixel this cycle.
- done  in  1  one-cycle pulse: drawer finished the primitive.
- colour  in  16  RGB565 colour; sampled with each accepted pixel.
- stall  out  1  back-pressure to the drawer.
- address  out  32  Avalon-MM byte address.
- write  out  1  Avalon-MM write request.
- writedata  out  16  Avalon-MM write data.
- waitrequest  in  1  Avalon-MM slave stall.
- idle  out  1  nothing buffered, in flight or pending.
- complete  out  1  one-cycle pulse: all pixels of the finished primitive are written.
- clip_count  out  16  saturating count of clipped pixels since reset.

## Operation

- Input stage (S1): every cycle with valid=1 the pixel is accepted unconditionally, whatever the value of `stall`. The stage computes in_range = (x < H_RES) && (y < V_RES). In-range pixels are registered into S1 as {addr, colour} with addr = BASE_ADDR + ((y*H_RES + x) << 1), computed in 32 bits. Out-of-range pixels are dropped and clip_count increments, saturating at 16'hFFFF.
- S1 pushes into the FIFO the cycle after acceptance. The FIFO never overflows. A push into a full FIFO is a design error, and the bench asserts on it.
- stall = (fifo_count >= FIFO_DEPTH-3). It is driven combinationally from the registered count. The margin covers one pixel in S1 plus one pixel already presented by the drawer.
- Write FSM:
  - W_IDLE: write=0. When the FIFO is non-empty, pop the head into the address/writedata registers, set write=1 and go to W_WRITE.
  - W_WRITE: hold address, writedata and write stable while waitrequest=1.
  - On the edge where waitrequest=0, the beat completes. If the FIFO is non-empty, load the next head and stay in W_WRITE (back-to-back, no bubble). Otherwise drop write and return to W_IDLE.
- Done tracking: a `done` pulse sets done_pending. complete pulses for one cycle on the first cycle with done_pending=1 and idle=1; that same edge clears done_pending. If done arrives while already idle (for example, every pixel was clipped), complete pulses on the next cycle.
- idle = FIFO empty && S1 empty && FSM in W_IDLE.
- Simultaneous push and pop: count is unchanged and both operations occur. FIFO pointers wrap modulo FIFO_DEPTH.

## Timing

- Reset values: stall=0, write=0, address=0, writedata=0, idle=1, complete=0, clip_count=0, FSM=W_IDLE, FIFO empty, done_pending=0.
- Reset asserted mid-operation: all state clears immediately, including the in-flight Avalon beat, which is abandoned.
- Latency with waitrequest=0: valid at cycle N, S1 at N+1, FIFO at N+2, write=1 with the address at N+3. Writes are accepted at 1 pixel per clock sustained.
- stall responds within the same cycle that count crosses the threshold. It deasserts the cycle count drops below FIFO_DEPTH-3.
- complete never coincides with write=1 for that primitive's pixels.

## Test plan

- Single pixel: x=10, y=2, colour=16'hF800, H_RES=640 -> exactly one write at N+3 with address=BASE_ADDR+0xA14, writedata=F800. done -> complete pulses one cycle after the write completes.
- Clip: pixels (640,0), (0,480) and (12'hFFF,5) -> no writes, clip_count=3. done -> complete pulses the next cycle.
- Back-pressure: waitrequest held at 1 while 20 pixels arrive, one per cycle, honouring stall -> stall rises at count 5. No pixel is lost. After waitrequest is released, 20 writes issue in input order with correct addresses.
- Wait-state hold: waitrequest=1 for 3 cycles on the first beat -> address and writedata are stable throughout. The second beat follows with no bubble.
- Streaming: 100 pixels of a horizontal line with waitrequest=0 -> 100 consecutive write cycles, addresses incrementing by 2, idle=0 throughout, complete exactly once.
- Reset mid-burst: reset_n pulled low during W_WRITE with 4 entries queued -> write=0 and idle=1 immediately. No writes occur after reset_n releases until new valid input arrives.

Source files
------------

// File: rtl/pixel_writer.sv
// Pixel stream sink: clips off-screen pixels, converts (x, y) to framebuffer byte
// addresses and issues single-beat Avalon-MM writes through a small write FIFO.
module pixel_writer #(
  parameter int unsigned H_RES      = 640,
  parameter int unsigned V_RES      = 480,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [11:0] x,
  input  logic [11:0] y,
  input  logic        valid,
  input  logic        done,
  input  logic [15:0] colour,
  output logic        stall,
  output logic [31:0] address,
  output logic        write,
  output logic [15:0] writedata,
  input  logic        waitrequest,
  output logic        idle,
  output logic        complete,
  output logic [15:0] clip_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [31:0] H_RES_W = 32'(H_RES);
  localparam logic [31:0] V_RES_W = 32'(V_RES);
  localparam logic [CNT_W-1:0] STALL_LVL = CNT_W'(FIFO_DEPTH - 3);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [31:0] pixel_addr(input logic [11:0] px, input logic [11:0] py);
    logic [31:0] idx;
    idx = {20'd0, py} * H_RES_W + {20'd0, px};
    return BASE_ADDR + (idx << 1);
  endfunction

  // ---- p0: drawer inputs, range test and address generation ----
  logic        in_range_p0;
  logic [31:0] addr_p0;

  assign in_range_p0 = ({20'd0, x} < H_RES_W) && ({20'd0, y} < V_RES_W);
  assign addr_p0     = pixel_addr(x, y);

  // ---- p1: accepted in-range pixel, pushed into the FIFO next edge ----
  logic        vld_p1;
  logic [31:0] addr_p1;
  logic [15:0] colour_p1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1     <= 1'b0;
      clip_count <= 16'd0;
    end else begin
      vld_p1 <= valid && in_range_p0;
      if (valid && !in_range_p0)
        clip_count <= sat_inc16(clip_count);
    end
  end

  always_ff @(posedge clock) begin
    if (valid && in_range_p0) begin
      addr_p1   <= addr_p0;
      colour_p1 <= colour;
    end
  end

  // ---- p2: write FIFO ----
  logic [47:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_count;
  logic             push;
  logic             pop;
  logic             fifo_empty;

  assign push       = vld_p1;
  assign fifo_empty = (fifo_count == '0);
  // Registered count keeps stall free of any path from the drawer inputs.
  assign stall      = (fifo_count >= STALL_LVL);

  always_ff @(posedge clock) begin
    if (push)
      fifo_mem[wr_ptr] <= {addr_p1, colour_p1};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // ---- p3: Avalon-MM write FSM ----
  typedef enum logic {W_IDLE, W_WRITE} wstate_t;
  wstate_t state;
  wstate_t state_nxt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      state <= W_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      W_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = W_WRITE;
        end
      end
      W_WRITE: begin
        if (!waitrequest) begin
          if (!fifo_empty)
            pop = 1'b1;
          else
            state_nxt = W_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      address   <= 32'd0;
      writedata <= 16'd0;
    end else if (pop) begin
      {address, writedata} <= fifo_mem[rd_ptr];
    end
  end

  assign write = (state == W_WRITE);

  // A done arriving on the same edge as complete belongs to the next primitive.
  logic done_pending;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      done_pending <= 1'b0;
    else if (done)
      done_pending <= 1'b1;
    else if (complete)
      done_pending <= 1'b0;
  end

  assign idle     = fifo_empty && !vld_p1 && (state == W_IDLE);
  assign complete = done_pending && idle;

endmodule

// File: tb/tb_pixel_writer.sv
// Directed bench for pixel_writer: a queue-based model of expected memory writes
// is checked every cycle, alongside hand-computed literal expectations.
module tb_pixel_writer;

  localparam int          H    = 640;
  localparam int          V    = 480;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] x = 12'd0;
  logic [11:0] y = 12'd0;
  logic        valid = 1'b0;
  logic        done = 1'b0;
  logic [15:0] colour = 16'd0;
  logic        waitrequest = 1'b0;
  logic        stall;
  logic [31:0] address;
  logic        write;
  logic [15:0] writedata;
  logic        idle;
  logic        complete;
  logic [15:0] clip_count;

  int          n_total = 0;
  int          n_pass  = 0;
  logic [47:0] exp_q[$];
  logic [15:0] mclip = 16'd0;
  bit          mpend = 1'b0;
  bit          exp_cmp;

  pixel_writer #(
    .H_RES(H), .V_RES(V), .BASE_ADDR(BASE), .FIFO_DEPTH(8)
  ) dut (
    .clock(clock), .reset_n(reset_n), .x(x), .y(y), .valid(valid), .done(done),
    .colour(colour), .stall(stall), .address(address), .write(write),
    .writedata(writedata), .waitrequest(waitrequest), .idle(idle),
    .complete(complete), .clip_count(clip_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] ref_addr(input logic [11:0] px, input logic [11:0] py);
    return BASE + (32'(py) * 32'(H) + 32'(px)) * 32'd2;
  endfunction

  // Model: every accepted in-range pixel must reach memory in order; idle means
  // nothing still owed to memory; complete fires once owed writes drain after done.
  always @(negedge clock) begin
    if (!reset_n) begin
      exp_q.delete();
      mclip = 16'd0;
      mpend = 1'b0;
      check("rst_write", write, 0);
      check("rst_idle", idle, 1);
      check("rst_stall", stall, 0);
      check("rst_complete", complete, 0);
      check("rst_address", address, 0);
    end else begin
      exp_cmp = mpend && (exp_q.size() == 0);
      check("idle", idle, exp_q.size() == 0);
      check("complete", complete, exp_cmp);
      check("clip_count", clip_count, mclip);
      if (dut.vld_p1)
        check("no_overflow", dut.fifo_count >= 8, 0);
      if (write) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL spurious_write: got address %0h with nothing owed", address);
        end else begin
          check("wr_address", address, exp_q[0][47:16]);
          check("wr_data", writedata, exp_q[0][15:0]);
          if (!waitrequest) void'(exp_q.pop_front());
        end
      end
      if (exp_cmp) mpend = 1'b0;
      if (done) mpend = 1'b1;
      if (valid) begin
        if (x < H && y < V) exp_q.push_back({ref_addr(x, y), colour});
        else if (mclip != 16'hFFFF) mclip = mclip + 16'd1;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_stall, sent, wr_cnt, cmp_cnt, idle_lo, fw, lw, cmp_at;
    logic [31:0] a_addr, b_addr;

    // Reset values
    repeat (3) step();
    @(negedge clock);
    check("reset_writedata", writedata, 0);
    check("reset_clip", clip_count, 0);
    check("reset_idle", idle, 1);
    step(); reset_n = 1'b1;
    repeat (3) step();

    // Single pixel (10,2): address 0xA14 at N+3, complete at N+4
    x = 12'd10; y = 12'd2; colour = 16'hF800; valid = 1'b1;     // N
    step(); valid = 1'b0; done = 1'b1;                            // N+1
    step(); done = 1'b0;                                          // N+2
    step(); @(negedge clock);                                     // N+3
    check("single_write", write, 1);
    check("single_addr", address, 32'h0000_0A14);
    check("single_data", writedata, 16'hF800);
    check("single_no_cmp", complete, 0);
    step(); @(negedge clock);                                     // N+4
    check("single_write_drop", write, 0);
    check("single_complete", complete, 1);
    step(); @(negedge clock);
    check("single_cmp_pulse", complete, 0);

    // Clip: three off-screen pixels, then done -> complete next cycle
    step(); x = 12'd640; y = 12'd0; valid = 1'b1;
    step(); x = 12'd0; y = 12'd480;
    step(); x = 12'hFFF; y = 12'd5;
    step(); valid = 1'b0; done = 1'b1;
    @(negedge clock);
    check("clip_no_write", write, 0);
    check("clip_idle", idle, 1);
    step(); done = 1'b0;
    @(negedge clock);
    check("clip_count3", clip_count, 16'd3);
    check("clip_complete", complete, 1);
    step(); @(negedge clock);
    check("clip_cmp_pulse", complete, 0);

    // Wait-state hold: 3 stall cycles on the first beat, second beat with no bubble
    a_addr = ref_addr(12'd100, 12'd50);
    b_addr = ref_addr(12'd101, 12'd50);
    step(); waitrequest = 1'b1; x = 12'd100; y = 12'd50; colour = 16'h07E0; valid = 1'b1; // N
    step(); x = 12'd101; colour = 16'h001F;                       // N+1
    step(); valid = 1'b0;                                         // N+2
    for (int i = 3; i <= 5; i++) begin
      step(); @(negedge clock);
      check("hold_write", write, 1);
      check("hold_addr", address, a_addr);
      check("hold_data", writedata, 16'h07E0);
    end
    step(); waitrequest = 1'b0; @(negedge clock);                // N+6
    check("hold_release_addr", address, a_addr);
    step(); @(negedge clock);                                     // N+7
    check("second_write", write, 1);
    check("second_addr", address, b_addr);
    check("second_data", writedata, 16'h001F);
    step(); @(negedge clock);
    check("second_done", write, 0);
    repeat (2) step();

    // Back-pressure: 20 pixels honouring stall, waitrequest held for 15 cycles
    first_stall = -1; sent = 0; wr_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      waitrequest = (i < 15);
      if (stall && first_stall < 0) first_stall = i;
      if (sent < 20 && !stall) begin
        x = 12'(sent * 3); y = 12'(sent + 1); colour = 16'(16'hA000 + sent); valid = 1'b1;
        sent++;
      end else begin
        valid = 1'b0;
      end
      @(negedge clock);
      if (write && !waitrequest) wr_cnt++;
      if (sent == 20 && idle && !valid) break;
    end
    check("bp_first_stall_cycle", first_stall, 7);
    check("bp_sent", sent, 20);
    check("bp_writes", wr_cnt, 20);
    check("bp_drained", exp_q.size(), 0);
    repeat (2) step();

    // Streaming: 100-pixel horizontal line with no wait states
    wr_cnt = 0; cmp_cnt = 0; idle_lo = 0; fw = -1; lw = -1; cmp_at = -1;
    for (int i = 0; i < 112; i++) begin
      if (i > 0) step();
      valid = (i < 100);
      x = 12'(i); y = 12'd200; colour = 16'(i);
      done = (i == 100);
      @(negedge clock);
      if (write) begin
        wr_cnt++;
        if (fw < 0) fw = i;
        lw = i;
      end
      if (complete) begin
        cmp_cnt++;
        cmp_at = i;
      end
      if (!idle) idle_lo++;
    end
    check("stream_writes", wr_cnt, 100);
    check("stream_first", fw, 3);
    check("stream_last", lw, 102);
    check("stream_idle_low", idle_lo, 102);
    check("stream_complete_once", cmp_cnt, 1);
    check("stream_complete_at", cmp_at, 103);
    step(); done = 1'b0;

    // Reset mid-burst: W_WRITE with 4 entries queued, then reset
    waitrequest = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(); x = 12'(i); y = 12'd9; colour = 16'h1234; valid = 1'b1;
    end
    step(); valid = 1'b0;                                         // N+6
    @(negedge clock);
    check("mid_write_before", write, 1);
    check("mid_count_before", dut.fifo_count, 4);
    step(); reset_n = 1'b0;
    @(negedge clock);
    check("mid_rst_write", write, 0);
    check("mid_rst_idle", idle, 1);
    step(); reset_n = 1'b1; waitrequest = 1'b0;
    wr_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(); @(negedge clock);
      if (write) wr_cnt++;
    end
    check("mid_no_writes", wr_cnt, 0);
    check("mid_idle_after", idle, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
